// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell evaluated per clock, LSB first.
// Optional signed-overflow output enabled with `define SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  output logic             fa_sum,
  output logic             fa_carry,
  output logic             fa_valid
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, ps_q, sum_q;
  logic [WIDTH-1:0] ps_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, cout_q, busy_q, done_q;
  logic             last;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q;
  assign ovf = ovf_q;
`endif

  // Taps are forced low outside SHIFT so an observer never sees stale bits.
  always_comb begin
    fa_valid = (state_q == SHIFT);
    fa_a     = fa_valid & a_q[0];
    fa_b     = fa_valid & b_q[0];
    fa_c     = fa_valid & c_q;
    fa_sum   = fa_a ^ fa_b ^ fa_c;
    fa_carry = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);
  end

  assign ps_d  = {fa_sum, ps_q[WIDTH-1:1]};
  assign cnt_d = cnt_q + 1'b1;
  assign last  = (cnt_q == CW'(WIDTH - 1));

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ps_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            c_q     <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          ps_q  <= ps_d;
          c_q   <= fa_carry;
          cnt_q <= cnt_d;
          if (last) begin
            sum_q   <= ps_d;
            cout_q  <= fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
            // fa_c on the final bit is the carry into the MSB.
            ovf_q   <= fa_c ^ fa_carry;
`endif
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, request to add the operands presented this cycle.
REQ-005 SHALL have ports a and b, input, WIDTH each, unsigned operands, sampled only when start is accepted.
REQ-006 SHALL have port cin, input, 1, carry-in, sampled with a and b.
REQ-007 SHALL have port busy, output, 1, high while an addition is in progress (SHIFT or DONE).
REQ-008 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-009 SHALL have ports sum (output, WIDTH) and cout (output, 1), last completed result.
REQ-010 SHALL have ports fa_a, fa_b, fa_c (outputs, 1 each): full-adder cell inputs for the current bit.
REQ-011 SHALL have ports fa_sum and fa_carry (outputs, 1 each): full-adder cell outputs for the current bit.
REQ-012 SHALL have port fa_valid, output, 1, high when the fa_* taps carry a live bit operation.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 In IDLE with start=1, SHALL at the clock edge load a, b into shift registers, load cin into the carry register, clear the bit counter, and enter SHIFT.
REQ-015 SHALL ignore start in SHIFT and DONE; operands are not resampled.
REQ-016 In SHIFT, fa_a/fa_b SHALL be bit 0 of the a/b shift registers and fa_c the carry register; fa_sum = fa_a^fa_b^fa_c and fa_carry = majority(fa_a,fa_b,fa_c), combinationally.
REQ-017 Each SHIFT edge SHALL shift a and b right by one, shift fa_sum into the MSB of the partial-sum register, load fa_carry into the carry register, and increment the counter.
REQ-018 After exactly WIDTH SHIFT edges SHALL enter DONE, loading sum from the completed partial-sum register and cout from fa_carry of bit WIDTH-1, in that same edge.
REQ-019 done SHALL be high exactly during the DONE cycle; DONE SHALL return to IDLE on the next edge unconditionally.
REQ-020 Latency: start accepted at edge E0, done high in cycle following edge E0+WIDTH; a new start is accepted no earlier than edge E0+WIDTH+2.
REQ-021 sum and cout SHALL hold their value between completions, including through SHIFT of the next operation.
REQ-022 fa_valid SHALL equal (state==SHIFT); fa_a, fa_b, fa_c SHALL be 0 when fa_valid=0.
REQ-023 Arithmetic: {cout,sum} SHALL equal a+b+cin modulo 2^(WIDTH+1).

Reset
REQ-024 rst=1 SHALL immediately, independent of clk, force state IDLE, counter, shift, partial-sum and carry registers to 0.
REQ-025 During/after reset: sum=0, cout=0, busy=0, done=0, fa_valid=0, all fa_* taps 0.
REQ-026 Reset mid-operation SHALL abandon the operation with no done pulse; the next start after release SHALL run normally.

Configuration
REQ-027 With macro SERIAL_ADDER_OVF_EN defined, SHALL add output ovf, 1 bit, loaded with sum at completion as the signed overflow (carry into MSB XOR cout), reset 0, held like sum.
REQ-028 Without SERIAL_ADDER_OVF_EN, the ovf port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 WIDTH=8, a=0x5A, b=0x3C, cin=0, start one cycle -> busy 9 cycles, done in cycle after 8th SHIFT edge, sum=0x96, cout=0.
REQ-030 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1 (OVF_EN build).
REQ-031 a=0x10, b=0x20; start re-pulsed with a=0xFF, b=0xFF during SHIFT -> sum=0x30, cout=0, second request dropped.
REQ-032 rst pulsed after 4th SHIFT edge -> busy=0, sum=0, no done; then a=0x01, b=0x02, cin=1 -> sum=0x04.
REQ-033 Full-adder checker bound to fa_* taps, sampled when fa_valid=1, over a=0xFF, b=0xFF, cin=1 and 200 random operands -> zero sum/carry mismatches, final sum=0xFF, cout=1.
